// File: rtl/dds_freq_ctrl.sv
// Frequency-control front end for the DDS: turns a frequency index into a tuning
// word by a sequential shift-add multiply and commits it glitch-free on an accumulator wrap.
module dds_freq_ctrl #(
    parameter int ACC_W        = 32,
    parameter int TW_STEP      = 1790,
    parameter int ADDR_MAX     = 1800,
    parameter int WRAP_TIMEOUT = 2400000
) (
    input  logic             Fg_CLK,
    input  logic             RESETn,
    input  logic [10:0]      Address,
    input  logic             FreqChng,
    input  logic             Phase_Wrap,
    output logic [ACC_W-1:0] Tword,
    output logic             Tword_load,
    output logic             Busy,
    output logic             Sat
);

    localparam int PROD_W = ACC_W + 11;
    localparam int TMR_W  = (WRAP_TIMEOUT > 1) ? $clog2(WRAP_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, MUL, WAIT_WRAP} state_t;

    state_t            state;
    logic [10:0]       operand;
    logic [10:0]       pend_op;
    logic              pend;
    logic [PROD_W-1:0] product;
    logic [3:0]        bit_cnt;
    logic [TMR_W-1:0]  timer;

    logic [10:0]       addr_clamped;
    logic [PROD_W-1:0] step_shifted;
    logic              commit;
    logic              overflow;
    logic              next_req;
    logic [10:0]       next_op;

    assign addr_clamped = (Address > 11'(ADDR_MAX)) ? 11'(ADDR_MAX) : Address;
    assign step_shifted = PROD_W'(TW_STEP) << bit_cnt;
    assign commit       = (state == WAIT_WRAP) &&
                          (Phase_Wrap || (timer == TMR_W'(WRAP_TIMEOUT - 1)));
    assign overflow     = |product[PROD_W-1:ACC_W];
    // A request arriving on the commit edge itself wins over an older pending one.
    assign next_req     = FreqChng | pend;
    assign next_op      = FreqChng ? addr_clamped : pend_op;
    assign Busy         = (state != IDLE);

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, matching the hardware it describes.
    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            state      <= IDLE;
            operand    <= '0;
            pend_op    <= '0;
            pend       <= 1'b0;
            product    <= '0;
            bit_cnt    <= '0;
            timer      <= '0;
            Tword      <= '0;
            Tword_load <= 1'b0;
            Sat        <= 1'b0;
        end else begin
            Tword_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (FreqChng) begin
                        operand <= addr_clamped;
                        product <= '0;
                        bit_cnt <= '0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    // One operand bit per edge, LSB first; the operand shifts down.
                    if (operand[0]) product <= product + step_shifted;
                    operand <= operand >> 1;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd10) begin
                        timer <= '0;
                        state <= WAIT_WRAP;
                    end
                    if (FreqChng) begin
                        pend    <= 1'b1;
                        pend_op <= addr_clamped;
                    end
                end
                WAIT_WRAP: begin
                    if (commit) begin
                        Tword      <= overflow ? '1 : product[ACC_W-1:0];
                        Sat        <= overflow;
                        Tword_load <= 1'b1;
                        pend       <= 1'b0;
                        if (next_req) begin
                            operand <= next_op;
                            product <= '0;
                            bit_cnt <= '0;
                            state   <= MUL;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                        if (FreqChng) begin
                            pend    <= 1'b1;
                            pend_op <= addr_clamped;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_freq_ctrl.sv
// Bench for dds_freq_ctrl: two parameterisations driven in lockstep and compared
// every cycle against a transaction-level model of request/commit timing.
module tb_dds_freq_ctrl;

    localparam int TMO   = 50;
    localparam int W_A   = 32;
    localparam int STP_A = 1790;
    localparam int W_B   = 16;
    localparam int STP_B = 100;
    localparam int AMAX  = 1800;

    logic              Fg_CLK;
    logic              RESETn;
    logic [10:0]       Address;
    logic              FreqChng;
    logic              Phase_Wrap;
    logic [W_A-1:0]    tword_a;
    logic              load_a, busy_a, sat_a;
    logic [W_B-1:0]    tword_b;
    logic              load_b, busy_b, sat_b;

    dds_freq_ctrl #(.ACC_W(W_A), .TW_STEP(STP_A), .ADDR_MAX(AMAX), .WRAP_TIMEOUT(TMO)) u_dut_a (
        .Fg_CLK(Fg_CLK), .RESETn(RESETn), .Address(Address), .FreqChng(FreqChng),
        .Phase_Wrap(Phase_Wrap), .Tword(tword_a), .Tword_load(load_a), .Busy(busy_a), .Sat(sat_a));

    dds_freq_ctrl #(.ACC_W(W_B), .TW_STEP(STP_B), .ADDR_MAX(AMAX), .WRAP_TIMEOUT(TMO)) u_dut_b (
        .Fg_CLK(Fg_CLK), .RESETn(RESETn), .Address(Address), .FreqChng(FreqChng),
        .Phase_Wrap(Phase_Wrap), .Tword(tword_b), .Tword_load(load_b), .Busy(busy_b), .Sat(sat_b));

    initial begin
        Fg_CLK = 1'b0;
        forever #5 Fg_CLK = ~Fg_CLK;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: a request accepted at edge S commits on the first edge
    // E >= S+12 carrying Phase_Wrap, or at E = S+11+TMO, whichever comes first.
    longint edge_no    = 0;
    longint start_edge = 0;
    bit     m_busy     = 0;
    bit     m_pend     = 0;
    int     m_op       = 0;
    int     m_pend_op  = 0;
    bit     m_load     = 0;
    longint m_tw_a     = 0;
    longint m_tw_b     = 0;
    bit     m_sat_a    = 0;
    bit     m_sat_b    = 0;

    function automatic int clampf(input int a);
        return (a > AMAX) ? AMAX : a;
    endfunction

    task automatic model_edge(input bit r, input bit fc, input int a, input bit pw);
        longint age, pa, pb, max_a, max_b;
        edge_no++;
        m_load = 0;
        if (!r) begin
            m_busy = 0; m_pend = 0; m_tw_a = 0; m_tw_b = 0; m_sat_a = 0; m_sat_b = 0;
            return;
        end
        if (!m_busy) begin
            if (fc) begin
                m_busy = 1; start_edge = edge_no; m_op = clampf(a);
            end
            return;
        end
        age = edge_no - start_edge;
        if (age >= 12 && (pw || age == 11 + TMO)) begin
            max_a = (longint'(1) << W_A) - 1;
            max_b = (longint'(1) << W_B) - 1;
            pa = longint'(m_op) * STP_A;
            pb = longint'(m_op) * STP_B;
            m_sat_a = (pa > max_a);
            m_sat_b = (pb > max_b);
            m_tw_a  = m_sat_a ? max_a : pa;
            m_tw_b  = m_sat_b ? max_b : pb;
            m_load  = 1;
            if (fc) begin
                start_edge = edge_no; m_op = clampf(a); m_pend = 0;
            end else if (m_pend) begin
                start_edge = edge_no; m_op = m_pend_op; m_pend = 0;
            end else begin
                m_busy = 0;
            end
        end else if (fc) begin
            m_pend = 1; m_pend_op = clampf(a);
        end
    endtask

    // Drive one edge's inputs, let the edge happen, then compare on the falling edge.
    task automatic cyc(input bit r, input bit fc, input int a, input bit pw);
        RESETn = r; FreqChng = fc; Address = 11'(a); Phase_Wrap = pw;
        @(posedge Fg_CLK);
        model_edge(r, fc, a, pw);
        @(negedge Fg_CLK);
        check("tword_a", 64'(tword_a), 64'(m_tw_a));
        check("load_a",  64'(load_a),  64'(m_load));
        check("busy_a",  64'(busy_a),  64'(m_busy));
        check("sat_a",   64'(sat_a),   64'(m_sat_a));
        check("tword_b", 64'(tword_b), 64'(m_tw_b));
        check("load_b",  64'(load_b),  64'(m_load));
        check("busy_b",  64'(busy_b),  64'(m_busy));
        check("sat_b",   64'(sat_b),   64'(m_sat_b));
    endtask

    task automatic idle(input int n, input bit pw);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, pw);
    endtask

    initial begin
        RESETn = 1'b0; FreqChng = 1'b0; Address = '0; Phase_Wrap = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Full-scale request with Phase_Wrap tied high: commit at the earliest edge.
        cyc(1, 1, 1800, 1);
        idle(16, 1);
        // Small request on the saturated instance clears Sat.
        cyc(1, 1, 5, 1);
        idle(16, 1);

        // Timeout path, with a wrap pulse injected during MUL.
        cyc(1, 1, 100, 0);
        idle(4, 0);
        cyc(1, 0, 0, 1);
        idle(60, 0);

        // Queued requests: latest pending value wins, in-flight one is kept.
        cyc(1, 1, 10, 0);
        idle(3, 0);
        cyc(1, 1, 20, 0);
        idle(9, 0);
        cyc(1, 1, 30, 0);
        idle(5, 0);
        cyc(1, 0, 0, 1);
        idle(14, 0);
        cyc(1, 0, 0, 1);
        idle(4, 0);

        // Out-of-range index is clamped.
        cyc(1, 1, 2047, 0);
        idle(14, 1);

        // Reset mid-multiply after a prior commit, then a normal request.
        cyc(1, 1, 10, 1);
        idle(14, 1);
        cyc(1, 1, 50, 0);
        cyc(1, 1, 60, 0);
        idle(3, 0);
        cyc(0, 0, 0, 0);
        idle(20, 1);
        cyc(1, 1, 7, 1);
        idle(14, 1);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 399) != 0),
                ($urandom_range(0, 11) == 0),
                int'($urandom_range(0, 2047)),
                ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_freq_ctrl.md
Name: dds_freq_ctrl

Overview:
- Sits between the rotary front end and the DDS phase accumulator.
- On each FreqChng pulse it converts the 11-bit frequency Address (0-1800) into an ACC_W-bit tuning word using a sequential shift-add multiply by TW_STEP.
- It commits the new word only on a phase-accumulator wrap (glitch-free frequency change), with a timeout fallback.
- Changes that arrive while an update is in flight are queued; latest value wins.

Parameters:
- ACC_W, 32, phase accumulator / tuning word width.
- TW_STEP, 1790, tuning-word increment per Address LSB (10 Hz at 24 MHz, 32-bit acc).
- ADDR_MAX, 1800, Address clamp value.
- WRAP_TIMEOUT, 2400000, max cycles spent waiting for Phase_Wrap before a forced commit.

Ports:
- Fg_CLK  in  1  system clock, 24 MHz.
- RESETn  in  1  synchronous active-low reset.
- Address  in  11  requested frequency index, sampled only when FreqChng=1.
- FreqChng  in  1  single-cycle request strobe.
- Phase_Wrap  in  1  single-cycle pulse from the DDS when the accumulator overflows.
- Tword  out  ACC_W  committed tuning word to the DDS.
- Tword_load  out  1  one-cycle pulse in the cycle Tword takes a new value.
- Busy  out  1  high whenever state != IDLE.
- Sat  out  1  sticky flag: last committed product saturated.

Behaviour:
- Interface: one clock, Fg_CLK; reset RESETn is synchronous and active-low, sampled on the rising edge of Fg_CLK.
- Reset (any state, mid-multiply included): state=IDLE, Tword=0, Tword_load=0, Busy=0, Sat=0, pending flag=0. Product, bit counter and timer are cleared.
- States: IDLE, MUL, WAIT_WRAP.
- IDLE: an edge with FreqChng=1 does the following:
  - latches min(Address, ADDR_MAX) into the operand register;
  - clears the product (ACC_W+11 bits wide) and the bit counter;
  - moves to MUL.
- MUL: exactly 11 cycles, one operand bit per edge, LSB first.
  - If the bit is 1, product += TW_STEP << bitidx.
  - After the 11th edge, go to WAIT_WRAP with the timer cleared.
- WAIT_WRAP: the timer increments each edge. The commit condition is Phase_Wrap=1, or timer==WRAP_TIMEOUT-1. Both true in the same edge gives a single commit.
- On commit:
  - Tword <= product saturated to 2^ACC_W-1 when product >= 2^ACC_W;
  - Sat <= overflow bit of that commit (updates every commit);
  - Tword_load=1 for exactly the next cycle.
- After commit: if the pending flag is set, load the pending operand, clear the flag and go to MUL. Otherwise go to IDLE.
- Latency: FreqChng sampled at edge N; MUL edges N+1..N+11; earliest commit at edge N+12. Tword/Tword_load are visible after N+12.
- FreqChng while in MUL or WAIT_WRAP (including the commit edge):
  - stores the clamped Address in the pending register and sets the pending flag;
  - a later request overwrites the earlier one;
  - the in-flight computation is never aborted.
- Phase_Wrap outside WAIT_WRAP is ignored (not remembered).
- Address=0 gives Tword=0, committed normally with Tword_load pulsing.
- Tword holds its value between commits. Tword_load never pulses on consecutive cycles unless separate commits occur.
- Arithmetic is unsigned throughout. Address > ADDR_MAX is clamped before multiply. Sat reflects only ACC_W overflow, not the clamp.

Test Plan:
- Reset, then FreqChng with Address=1800 and Phase_Wrap tied high. Required: Busy for 12 cycles, Tword=3222000 with Tword_load high for one cycle at N+13, Sat=0.
- Address=100 with Phase_Wrap held low and WRAP_TIMEOUT=50. Required: commit of Tword=179000 exactly 50 cycles after entering WAIT_WRAP. A Phase_Wrap pulse injected in MUL does not cause an early commit.
- FreqChng Address=10, then FreqChng Address=20 and FreqChng Address=30 during MUL/WAIT_WRAP. Required: commit 17900, then Busy stays high, then a second commit of 53700 only; never 35800.
- ACC_W=16, TW_STEP=100, Address=1800. Required: Tword=65535, Sat=1. Next request Address=5 gives Tword=500, Sat=0.
- Address=2047. Required: clamped to 1800, Tword=3222000.
- Assert RESETn=0 for one cycle mid-MUL after a prior commit of 17900. Required: Tword=0, Busy=0, pending cleared, no Tword_load. A following FreqChng operates normally.
